// File: rtl/divider_share.sv
// divider_share
//   Round-robin arbiter and sequencer that lets N_REQ requesters take turns on
//   a single shared divider. One division is in flight at a time: a request is
//   accepted in IDLE, issued to the divider, its completion awaited, and the
//   quotient/remainder returned to the granted requester as a one-cycle pulse.
//
// Parameters
//   N_REQ  number of requesters (>= 2)
//   WIDTH  operand/result width, must match the attached divider
//
// Ports
//   i_clk, i_cg, i_rst      clock, clock gate (state holds while low),
//                           synchronous active-high reset
//   i_reqValid/o_reqReady   per-requester handshake, o_reqReady is one-hot
//   i_reqDividend/Divisor   packed operands, requester k at [k*WIDTH +: WIDTH]
//   o_rspValid              one-cycle response pulse to the originating requester
//   o_rspQuotient/Remainder shared result buses, valid with o_rspValid
//   o_divBegin/Dividend/Divisor   drive the divider's start and operands
//   i_divBusy/Quotient/Remainder  divider status and results
//
// Configuration
//   DIVIDER_SHARE_ZERO_BYPASS_EN  when defined, a zero divisor skips the
//   divider and answers directly with quotient all-ones, remainder = dividend.

module divider_share #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 8
) (
  input  logic                   i_clk,
  input  logic                   i_cg,
  input  logic                   i_rst,
  input  logic [N_REQ-1:0]       i_reqValid,
  output logic [N_REQ-1:0]       o_reqReady,
  input  logic [N_REQ*WIDTH-1:0] i_reqDividend,
  input  logic [N_REQ*WIDTH-1:0] i_reqDivisor,
  output logic [N_REQ-1:0]       o_rspValid,
  output logic [WIDTH-1:0]       o_rspQuotient,
  output logic [WIDTH-1:0]       o_rspRemainder,
  output logic                   o_divBegin,
  output logic [WIDTH-1:0]       o_divDividend,
  output logic [WIDTH-1:0]       o_divDivisor,
  input  logic                   i_divBusy,
  input  logic [WIDTH-1:0]       i_divQuotient,
  input  logic [WIDTH-1:0]       i_divRemainder
);

  localparam int PTR_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_RESP  = 2'd3;

  logic [1:0]       state_q, state_d;
  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic [PTR_W-1:0] idx_q, idx_d;
  logic [WIDTH-1:0] dividend_q, dividend_d;
  logic [WIDTH-1:0] divisor_q, divisor_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             sawBusy_q, sawBusy_d;

  logic [PTR_W-1:0] pick;
  logic [PTR_W-1:0] pickNext;
  logic             found;
  logic             accept;
  logic [WIDTH-1:0] pickDividend;
  logic [WIDTH-1:0] pickDivisor;

  // Round-robin search: first valid index at or after ptr, wrapping.
  always_comb begin
    int j;
    j     = 0;
    found = 1'b0;
    pick  = ptr_q;
    for (int i = 0; i < N_REQ; i++) begin
      j = int'(ptr_q) + i;
      if (j >= N_REQ) j = j - N_REQ;
      if (!found && i_reqValid[j]) begin
        found = 1'b1;
        pick  = PTR_W'(j);
      end
    end
  end

  assign pickNext     = (pick == PTR_W'(N_REQ - 1)) ? '0 : pick + PTR_W'(1);
  assign pickDividend = i_reqDividend[pick*WIDTH +: WIDTH];
  assign pickDivisor  = i_reqDivisor[pick*WIDTH +: WIDTH];

  // Grant only in IDLE with the clock enabled; reset also masks it so all
  // outputs read 0 while reset is applied.
  always_comb begin
    o_reqReady = '0;
    if (state_q == ST_IDLE && i_cg && !i_rst && found) o_reqReady[pick] = 1'b1;
  end

  assign accept = |(i_reqValid & o_reqReady);

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    idx_d      = idx_q;
    dividend_d = dividend_q;
    divisor_d  = divisor_q;
    quot_d     = quot_q;
    rem_d      = rem_q;
    sawBusy_d  = sawBusy_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          idx_d      = pick;
          dividend_d = pickDividend;
          divisor_d  = pickDivisor;
          ptr_d      = pickNext;
          state_d    = ST_ISSUE;
`ifdef DIVIDER_SHARE_ZERO_BYPASS_EN
          if (pickDivisor == '0) begin
            quot_d  = '1;
            rem_d   = pickDividend;
            state_d = ST_RESP;
          end
`endif
        end
      end
      ST_ISSUE: begin
        sawBusy_d = 1'b0;
        state_d   = ST_WAIT;
      end
      ST_WAIT: begin
        // Completion is a busy high-to-low, so a divider that has not yet
        // raised busy is not mistaken for a finished one.
        if (i_divBusy) sawBusy_d = 1'b1;
        if (sawBusy_q && !i_divBusy) begin
          quot_d  = i_divQuotient;
          rem_d   = i_divRemainder;
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q    <= ST_IDLE;
      ptr_q      <= '0;
      idx_q      <= '0;
      dividend_q <= '0;
      divisor_q  <= '0;
      quot_q     <= '0;
      rem_q      <= '0;
      sawBusy_q  <= 1'b0;
    end else if (i_cg) begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      idx_q      <= idx_d;
      dividend_q <= dividend_d;
      divisor_q  <= divisor_d;
      quot_q     <= quot_d;
      rem_q      <= rem_d;
      sawBusy_q  <= sawBusy_d;
    end
  end

  // Pulses are decoded from state, so they stretch across gated cycles.
  always_comb begin
    o_rspValid = '0;
    if (state_q == ST_RESP && !i_rst) o_rspValid[idx_q] = 1'b1;
  end

  assign o_divBegin     = (state_q == ST_ISSUE) && !i_rst;
  assign o_divDividend  = dividend_q;
  assign o_divDivisor   = divisor_q;
  assign o_rspQuotient  = quot_q;
  assign o_rspRemainder = rem_q;

endmodule

// File: tb/tb_divider_share.sv
// tb_divider_share
//   Scoreboard bench for divider_share. A behavioural divider sits on the
//   divider port (random busy length, gated by the same clock gate). The
//   driver issues requests and pushes the expected response on acceptance;
//   a monitor pops and compares whenever a response pulse appears.

module tb_divider_share;

  localparam int N = 4;
  localparam int W = 8;

  typedef struct {
    int         k;
    logic [W-1:0] q;
    logic [W-1:0] r;
    int         acc;
    bit         byp;
    int         gcnt;
  } exp_t;

  logic           clk = 1'b0;
  logic           rst;
  logic           cg;
  logic [N-1:0]   reqValid;
  logic [N-1:0]   reqReady;
  logic [N*W-1:0] reqDividend;
  logic [N*W-1:0] reqDivisor;
  logic [N-1:0]   rspValid;
  logic [W-1:0]   rspQ;
  logic [W-1:0]   rspR;
  logic           divBegin;
  logic [W-1:0]   divDividend;
  logic [W-1:0]   divDivisor;
  logic           divBusy;
  logic [W-1:0]   divQ;
  logic [W-1:0]   divR;

  int vectors     = 0;
  int miscompares = 0;
  int cycleCount  = 0;

  // divider model state
  logic [W-1:0] pendQ, pendR;
  int           divCnt;
  int           lastLat = 0;
  int           forceLat = 0;

  // driver / model state
  bit           pendValid [N];
  logic [W-1:0] pendA [N];
  logic [W-1:0] pendB [N];
  int           refill [N];
  int           modelPtr;
  bit           dutBusy;
  bit           checkIssue;
  bit           issueExpBegin;
  logic [W-1:0] issueA, issueB;
  bit           cgNext;
  int           grantLog [$];
  exp_t         expQ [$];

  // monitor state
  bit           holdPulse;
  bit           popped;
  exp_t         monE;
  int           wantLat;

  always #5 clk = ~clk;

  always @(posedge clk) cycleCount <= cycleCount + 1;

  divider_share #(.N_REQ(N), .WIDTH(W)) dut (
    .i_clk          (clk),
    .i_cg           (cg),
    .i_rst          (rst),
    .i_reqValid     (reqValid),
    .o_reqReady     (reqReady),
    .i_reqDividend  (reqDividend),
    .i_reqDivisor   (reqDivisor),
    .o_rspValid     (rspValid),
    .o_rspQuotient  (rspQ),
    .o_rspRemainder (rspR),
    .o_divBegin     (divBegin),
    .o_divDividend  (divDividend),
    .o_divDivisor   (divDivisor),
    .i_divBusy      (divBusy),
    .i_divQuotient  (divQ),
    .i_divRemainder (divR)
  );

  // Behavioural divider: busy for L enabled cycles after a begin, result
  // presented as busy falls. Divide by zero yields all-ones / dividend.
  always @(posedge clk) begin
    int l;
    if (rst) begin
      divBusy <= 1'b0;
      divQ    <= '0;
      divR    <= '0;
      divCnt  <= 0;
    end else if (cg) begin
      if (divBegin && !divBusy) begin
        l = (forceLat != 0) ? forceLat : int'($urandom_range(1, 12));
        divBusy <= 1'b1;
        divCnt  <= l;
        lastLat <= l;
        if (divDivisor == '0) begin
          pendQ <= '1;
          pendR <= divDividend;
        end else begin
          pendQ <= divDividend / divDivisor;
          pendR <= divDividend % divDivisor;
        end
      end else if (divBusy) begin
        if (divCnt == 1) begin
          divBusy <= 1'b0;
          divQ    <= pendQ;
          divR    <= pendR;
        end
        divCnt <= divCnt - 1;
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] want);
    vectors++;
    if (act !== want) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, want, cycleCount);
    end
  endtask

  task automatic timeoutFail(input string tag);
    vectors++;
    miscompares++;
    $display("[TB] FAIL timeout %s: DUT did not finish in budget (cycle %0d)", tag, cycleCount);
  endtask

  function automatic bit anyPending();
    bit any = 1'b0;
    for (int k = 0; k < N; k++) if (pendValid[k]) any = 1'b1;
    return any;
  endfunction

  task automatic acceptReq(input int k);
    exp_t e;
    logic [W-1:0] a, b;
    a = pendA[k];
    b = pendB[k];
    e.k = k;
    if (b == '0) begin
      e.q = '1;
      e.r = a;
    end else begin
      e.q = a / b;
      e.r = a % b;
    end
`ifdef DIVIDER_SHARE_ZERO_BYPASS_EN
    e.byp = (b == '0);
`else
    e.byp = 1'b0;
`endif
    e.acc  = cycleCount;
    e.gcnt = 0;
    expQ.push_back(e);
    dutBusy       = 1'b1;
    modelPtr      = (k + 1) % N;
    grantLog.push_back(k);
    checkIssue    = 1'b1;
    issueExpBegin = !e.byp;
    issueA        = a;
    issueB        = b;
    if (refill[k] > 0) begin
      refill[k]--;
      pendA[k] = W'($urandom);
      pendB[k] = W'($urandom_range(1, 255));
    end else begin
      pendValid[k] = 1'b0;
    end
  endtask

  // One clock of stimulus: drive at the falling edge, then check the grant
  // against the round-robin rule and record any acceptance.
  task automatic applyStimulus();
    int pred;
    bit acc;
    @(negedge clk);
    for (int k = 0; k < N; k++) begin
      reqValid[k]           = pendValid[k];
      reqDividend[k*W +: W] = pendA[k];
      reqDivisor[k*W +: W]  = pendB[k];
    end
    cg = cgNext;
    #1;
    if (checkIssue) begin
      checkIssue = 1'b0;
      checkOutput("divBegin", 32'(divBegin), 32'(issueExpBegin));
      if (issueExpBegin) begin
        checkOutput("divDividend", 32'(divDividend), 32'(issueA));
        checkOutput("divDivisor", 32'(divDivisor), 32'(issueB));
      end
    end
    pred = -1;
    for (int i = 0; i < N; i++) begin
      int j = (modelPtr + i) % N;
      if (pred < 0 && pendValid[j]) pred = j;
    end
    acc = 1'b0;
    if (!dutBusy && cg && pred >= 0) begin
      checkOutput("grant", 32'(reqReady), 32'(1) << pred);
      acceptReq(pred);
      acc = 1'b1;
    end else begin
      checkOutput("readyLow", 32'(reqReady), 32'(0));
    end
    if (!acc && rspValid != '0 && cg && dutBusy) dutBusy = 1'b0;
  endtask

  task automatic doReset();
    for (int k = 0; k < N; k++) begin
      pendValid[k] = 1'b0;
      refill[k]    = 0;
    end
    @(negedge clk);
    rst      = 1'b1;
    cg       = 1'b1;
    cgNext   = 1'b1;
    reqValid = '0;
    #1;
    expQ.delete();
    dutBusy    = 1'b0;
    modelPtr   = 0;
    checkIssue = 1'b0;
    checkOutput("rstReady", 32'(reqReady), 32'(0));
    checkOutput("rstRspValid", 32'(rspValid), 32'(0));
    checkOutput("rstDivBegin", 32'(divBegin), 32'(0));
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    checkOutput("postRstRspValid", 32'(rspValid), 32'(0));
    checkOutput("postRstDivBegin", 32'(divBegin), 32'(0));
    checkOutput("postRstQuot", 32'(rspQ), 32'(0));
    checkOutput("postRstRem", 32'(rspR), 32'(0));
    checkOutput("postRstDivDividend", 32'(divDividend), 32'(0));
    checkOutput("postRstDivDivisor", 32'(divDivisor), 32'(0));
  endtask

  task automatic runUntilIdle(input int maxCycles, input string tag);
    int n = 0;
    while ((expQ.size() > 0 || dutBusy || anyPending()) && n < maxCycles) begin
      applyStimulus();
      n++;
    end
    if (expQ.size() > 0 || dutBusy || anyPending()) timeoutFail(tag);
  endtask

  task automatic runUntilAccepted(input int maxCycles, input string tag);
    int g = grantLog.size();
    int n = 0;
    while (grantLog.size() == g && n < maxCycles) begin
      applyStimulus();
      n++;
    end
    if (grantLog.size() == g) timeoutFail(tag);
  endtask

  task automatic setReq(input int k, input logic [W-1:0] a, input logic [W-1:0] b);
    pendA[k]     = a;
    pendB[k]     = b;
    pendValid[k] = 1'b1;
  endtask

  // Monitor: pops one expectation per response pulse (a pulse stretched by
  // gating counts once) and checks target, values and latency.
  always @(negedge clk) begin
    #2;
    if (rst) begin
      holdPulse = 1'b0;
    end else begin
      popped = 1'b0;
      if (rspValid != '0 && !holdPulse) begin
        if (expQ.size() == 0) begin
          checkOutput("rspUnexpected", 32'(rspValid), 32'(0));
        end else begin
          monE   = expQ.pop_front();
          popped = 1'b1;
          checkOutput("rspValid", 32'(rspValid), 32'(1) << monE.k);
          checkOutput("rspQuotient", 32'(rspQ), 32'(monE.q));
          checkOutput("rspRemainder", 32'(rspR), 32'(monE.r));
          wantLat = (monE.byp ? 1 : lastLat + 3) + monE.gcnt;
          checkOutput("rspLatency", 32'(cycleCount - monE.acc), 32'(wantLat));
        end
      end
      holdPulse = (rspValid != '0) && !cg;
      if (!popped && expQ.size() > 0 && !cg) expQ[0].gcnt = expQ[0].gcnt + 1;
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not complete");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int order2 [4];
    int order3 [6];
    order2 = '{0, 1, 2, 3};
    order3 = '{0, 2, 0, 2, 0, 2};
    rst         = 1'b1;
    cg          = 1'b1;
    cgNext      = 1'b1;
    reqValid    = '0;
    reqDividend = '0;
    reqDivisor  = '0;
    for (int k = 0; k < N; k++) begin
      pendValid[k] = 1'b0;
      pendA[k]     = '0;
      pendB[k]     = '0;
      refill[k]    = 0;
    end
    modelPtr = 0;
    dutBusy  = 1'b0;

    $display("[TB] reset");
    doReset();

    $display("[TB] single request 100/7");
    setReq(0, 8'd100, 8'd7);
    runUntilIdle(60, "single");

    $display("[TB] four simultaneous requests");
    doReset();
    grantLog.delete();
    setReq(0, 8'd200, 8'd3);
    setReq(1, 8'd50, 8'd5);
    setReq(2, 8'd9, 8'd9);
    setReq(3, 8'd255, 8'd16);
    runUntilIdle(200, "four");
    checkOutput("fourCount", 32'(grantLog.size()), 32'(4));
    for (int i = 0; i < 4 && i < grantLog.size(); i++)
      checkOutput("fourOrder", 32'(grantLog[i]), 32'(order2[i]));

    $display("[TB] requesters 0 and 2 held valid");
    grantLog.delete();
    setReq(0, W'($urandom), W'($urandom_range(1, 255)));
    setReq(2, W'($urandom), W'($urandom_range(1, 255)));
    refill[0] = 2;
    refill[2] = 2;
    runUntilIdle(300, "pair");
    checkOutput("pairCount", 32'(grantLog.size()), 32'(6));
    for (int i = 0; i < 6 && i < grantLog.size(); i++)
      checkOutput("pairOrder", 32'(grantLog[i]), 32'(order3[i]));

    $display("[TB] zero divisor 77/0");
    setReq(1, 8'd77, 8'd0);
    runUntilIdle(60, "zero");

    $display("[TB] reset during wait");
    forceLat = 10;
    setReq(1, 8'd60, 8'd7);
    runUntilAccepted(20, "rstAccept");
    repeat (3) applyStimulus();
    doReset();
    grantLog.delete();
    setReq(1, 8'd90, 8'd4);
    setReq(3, 8'd33, 8'd8);
    runUntilIdle(100, "postRst");
    checkOutput("postRstFirstGrant", 32'(grantLog.size() > 0 ? grantLog[0] : -1), 32'(1));

    $display("[TB] clock gate during wait");
    setReq(2, 8'd123, 8'd10);
    runUntilAccepted(20, "cgAccept");
    repeat (3) applyStimulus();
    cgNext = 1'b0;
    repeat (5) applyStimulus();
    cgNext = 1'b1;
    runUntilIdle(60, "cg");
    forceLat = 0;

    $display("[TB] random traffic");
    for (int c = 0; c < 1500; c++) begin
      for (int k = 0; k < N; k++) begin
        if (!pendValid[k] && $urandom_range(0, 9) < 3) begin
          if ($urandom_range(0, 7) == 0) setReq(k, W'($urandom), '0);
          else setReq(k, W'($urandom), W'($urandom));
        end
      end
      cgNext = ($urandom_range(0, 9) != 0);
      applyStimulus();
    end
    cgNext = 1'b1;
    runUntilIdle(400, "drain");

    repeat (3) @(negedge clk);
    #3;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
